// File: rtl/rx_5b4b_decode.sv
// 5B/4B serial frame receiver: a start bit, two 5B symbols sent LSB-first, and a stop bit.
// It decodes one byte per frame and reports symbol and framing errors.
module rx_5b4b_decode #(
  parameter int BIT_CLKS  = 362,
  parameter int HALF_CLKS = 181
) (
  input  logic       CLK_50M,
  input  logic       RESET_N,
  input  logic       RXD_5B,
  output logic [7:0] DATA,
  output logic       DATA_VALID,
  output logic       SYM_ERR,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_COUNT,
  output logic       BUSY,
  output logic [7:0] LED
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK,
    ST_DECODE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bitIdx_q, bitIdx_d;
  logic [9:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            symErr_q, symErr_d;
  logic            frameErr_q, frameErr_d;
  logic [7:0]      errCnt_q, errCnt_d;
  logic            errEvent;
  logic            sync1_q, line_q, hist_q;
  logic [4:0]      loDec, hiDec;

  // Returns {valid, nibble}; valid is 0 for any code outside the 16-entry table.
  function automatic logic [4:0] dec5b(input logic [4:0] code);
    logic [4:0] r;
    case (code)
      5'b11110: r = 5'h10;
      5'b01001: r = 5'h11;
      5'b10100: r = 5'h12;
      5'b10101: r = 5'h13;
      5'b01010: r = 5'h14;
      5'b01011: r = 5'h15;
      5'b01110: r = 5'h16;
      5'b01111: r = 5'h17;
      5'b10010: r = 5'h18;
      5'b10011: r = 5'h19;
      5'b10110: r = 5'h1A;
      5'b10111: r = 5'h1B;
      5'b11010: r = 5'h1C;
      5'b11011: r = 5'h1D;
      5'b11100: r = 5'h1E;
      5'b11101: r = 5'h1F;
      default:  r = 5'h00;
    endcase
    return r;
  endfunction

  assign loDec = dec5b(shift_q[4:0]);
  assign hiDec = dec5b(shift_q[9:5]);

  // The flops reset high so that a line idling high does not look like a start edge when reset is released.
  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 1'b1;
      line_q  <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= RXD_5B;
      line_q  <= sync1_q;
      hist_q  <= line_q;
    end
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      symErr_q   <= 1'b0;
      frameErr_q <= 1'b0;
      errCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      symErr_q   <= symErr_d;
      frameErr_q <= frameErr_d;
      errCnt_q   <= errCnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    symErr_d   = 1'b0;
    frameErr_d = 1'b0;
    errCnt_d   = errCnt_q;
    errEvent   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hist_q && !line_q) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          if (!line_q) begin
            cnt_d    = '0;
            bitIdx_d = '0;
            state_d  = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // New bits enter at the top, so after ten shifts the first bit received sits in shift_q[0].
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {line_q, shift_q[9:1]};
          if (bitIdx_q == 4'd9) begin
            state_d = ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (line_q) begin
            state_d = ST_DECODE;
          end else begin
            frameErr_d = 1'b1;
            errEvent   = 1'b1;
            state_d    = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (line_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (loDec[4] && hiDec[4]) begin
          data_d  = {hiDec[3:0], loDec[3:0]};
          valid_d = 1'b1;
        end else begin
          symErr_d = 1'b1;
          errEvent = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (errEvent && (errCnt_q != 8'hFF)) begin
      errCnt_d = errCnt_q + 8'd1;
    end
  end

  assign DATA       = data_q;
  assign LED        = data_q;
  assign DATA_VALID = valid_q;
  assign SYM_ERR    = symErr_q;
  assign FRAME_ERR  = frameErr_q;
  assign ERR_COUNT  = errCnt_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_5b4b_decode.sv
// Bench for rx_5b4b_decode. It drives serial 5B frames and uses a scoreboard queue
// to match each output pulse with the frame that should have produced it.
`timescale 1ns/1ps
module tb_rx_5b4b_decode;

  localparam int BIT_CLKS  = 362;
  localparam int HALF_CLKS = 181;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic       rxd  = 1'b1;
  logic [7:0] DATA;
  logic       DATA_VALID;
  logic       SYM_ERR;
  logic       FRAME_ERR;
  logic [7:0] ERR_COUNT;
  logic       BUSY;
  logic [7:0] LED;

  typedef enum int {K_DATA, K_SYM, K_FRAME} kind_t;

  typedef struct {
    logic [4:0] loCode;
    logic [4:0] hiCode;
    logic       stopBit;
    kind_t      kind;
    logic [7:0] byteVal;
  } vec_t;

  typedef struct {
    kind_t      kind;
    logic [7:0] dataExp;
    logic [7:0] errExp;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monE;
  logic [2:0] monPulseExp;
  vec_t       vecs[8];
  int         vecCount  = 0;
  int         missCount = 0;
  logic [7:0] lastGood  = 8'h00;
  logic [7:0] errModel  = 8'h00;

  rx_5b4b_decode #(
    .BIT_CLKS (BIT_CLKS),
    .HALF_CLKS(HALF_CLKS)
  ) dut (
    .CLK_50M   (clk),
    .RESET_N   (rstN),
    .RXD_5B    (rxd),
    .DATA      (DATA),
    .DATA_VALID(DATA_VALID),
    .SYM_ERR   (SYM_ERR),
    .FRAME_ERR (FRAME_ERR),
    .ERR_COUNT (ERR_COUNT),
    .BUSY      (BUSY),
    .LED       (LED)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input kind_t kind, input logic [7:0] byteVal);
    exp_t e;
    if (kind == K_DATA) lastGood = byteVal;
    else if (errModel != 8'hFF) errModel = errModel + 8'd1;
    e.kind    = kind;
    e.dataExp = lastGood;
    e.errExp  = errModel;
    expQ.push_back(e);
  endtask

  task automatic sendBit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // The line is left at the stop-bit value, so a low stop bit stays low until the caller releases it.
  task automatic applyStimulus(input logic [4:0] lo, input logic [4:0] hi, input logic stopBit,
                               input kind_t kind, input logic [7:0] byteVal);
    pushExpect(kind, byteVal);
    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(lo[i]);
    for (int i = 0; i < 5; i++) sendBit(hi[i]);
    sendBit(stopBit);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  // Any pulse must match the oldest outstanding frame; a pulse with nothing queued is spurious.
  always @(negedge clk) begin
    if (rstN && (DATA_VALID || SYM_ERR || FRAME_ERR)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", {29'd0, DATA_VALID, SYM_ERR, FRAME_ERR}, 32'd0);
      end else begin
        monE = expQ.pop_front();
        case (monE.kind)
          K_DATA:  monPulseExp = 3'b100;
          K_SYM:   monPulseExp = 3'b010;
          default: monPulseExp = 3'b001;
        endcase
        checkOutput("pulseKind", {29'd0, DATA_VALID, SYM_ERR, FRAME_ERR}, {29'd0, monPulseExp});
        checkOutput("data", DATA, monE.dataExp);
        checkOutput("led", LED, monE.dataExp);
        checkOutput("errCount", ERR_COUNT, monE.errExp);
      end
    end
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation did not finish, vecCount=%0d", vecCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{5'b01011, 5'b10110, 1'b1, K_DATA,  8'hA5};
    vecs[1] = '{5'b00000, 5'b10110, 1'b1, K_SYM,   8'h00};
    vecs[2] = '{5'b11110, 5'b11110, 1'b1, K_DATA,  8'h00};
    vecs[3] = '{5'b11101, 5'b01001, 1'b1, K_DATA,  8'h1F};
    vecs[4] = '{5'b11111, 5'b00000, 1'b1, K_SYM,   8'h00};
    vecs[5] = '{5'b10100, 5'b11100, 1'b0, K_FRAME, 8'h00};
    vecs[6] = '{5'b01111, 5'b11010, 1'b1, K_DATA,  8'hC7};
    vecs[7] = '{5'b10011, 5'b01110, 1'b1, K_DATA,  8'h69};

    rstN = 1'b0;
    rxd  = 1'b1;
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    repeat (500) @(negedge clk);
    checkOutput("idleData", DATA, 8'h00);
    checkOutput("idleLed", LED, 8'h00);
    checkOutput("idleErrCount", ERR_COUNT, 8'h00);
    checkOutput("idleBusy", BUSY, 1'b0);
    checkOutput("idlePulses", {29'd0, DATA_VALID, SYM_ERR, FRAME_ERR}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].loCode, vecs[v].hiCode, vecs[v].stopBit, vecs[v].kind, vecs[v].byteVal);
      sendBit(1'b1);
      waitDrain("tableDrain");
      checkOutput("tableBusyIdle", BUSY, 1'b0);
    end

    // A low stop bit followed by a held-low line must not start a new frame.
    applyStimulus(5'b01011, 5'b10110, 1'b0, K_FRAME, 8'h00);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("breakBusy", BUSY, 1'b1);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("breakReleaseBusy", BUSY, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    checkOutput("breakNoRetrigger", BUSY, 1'b0);
    waitDrain("breakDrain");

    rxd = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("glitchBusy", BUSY, 1'b1);
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("glitchBusyIdle", BUSY, 1'b0);
    applyStimulus(5'b11110, 5'b11110, 1'b1, K_DATA, 8'h00);
    waitDrain("glitchFrameDrain");

    applyStimulus(5'b11010, 5'b10101, 1'b1, K_DATA, 8'h3C);
    applyStimulus(5'b11101, 5'b11101, 1'b1, K_DATA, 8'hFF);
    waitDrain("backToBackDrain");
    checkOutput("backToBackData", DATA, 8'hFF);

    // A reset partway through the data bits must discard the partial frame without producing any output.
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    rstN = 1'b0;
    rxd  = 1'b1;
    #1;
    checkOutput("resetBusy", BUSY, 1'b0);
    checkOutput("resetData", DATA, 8'h00);
    checkOutput("resetLed", LED, 8'h00);
    checkOutput("resetErrCount", ERR_COUNT, 8'h00);
    lastGood = 8'h00;
    errModel = 8'h00;
    expQ.delete();
    @(negedge clk);
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("postResetData", DATA, 8'h00);
    checkOutput("postResetBusy", BUSY, 1'b0);
    applyStimulus(5'b10110, 5'b01011, 1'b1, K_DATA, 8'h5A);
    waitDrain("postResetDrain");

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/rx_5b4b_decode.md
Name: rx_5b4b_decode

Overview:
- Downstream stage of the 115200-baud 4B/5B transmit stage.
- Receives its 12-bit serial frame: start bit, ten 5B code bits, stop bit.
- Decodes the two 5B symbols back to one byte and presents it with a one-cycle valid strobe.
- Flags symbol and framing errors and counts them; drives the board LEDs with the last good byte.

Parameters:
- BIT_CLKS, 362: CLK_50M cycles per line bit; matches the 5B transmit bit period, about 138.1 kbaud.
- HALF_CLKS, 181: cycles from the start-bit falling edge to the start-bit mid-sample.

Ports:
- CLK_50M  input  1  50 MHz system clock; the only clock.
- RESET_N  input  1  asynchronous, active-low reset.
- RXD_5B  input  1  serial 5B line; idles high; asynchronous to CLK_50M.
- DATA  output  8  last correctly decoded byte.
- DATA_VALID  output  1  one-cycle pulse when DATA updates.
- SYM_ERR  output  1  one-cycle pulse: invalid 5B code received.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- ERR_COUNT  output  8  saturating count of SYM_ERR plus FRAME_ERR events.
- BUSY  output  1  high in every state except IDLE.
- LED  output  8  mirrors DATA.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - State goes to IDLE; all counters and the shift register clear.
  - All outputs go to 0, including DATA, LED and ERR_COUNT.
  - Synchroniser flops reset to 1.
  - Reset takes effect immediately, including mid-frame; no partial output is produced.
- Input path: RXD_5B passes through a 2-flop synchroniser, plus one history flop for edge detection.
  - "Line" below means the synchronised value.
  - Latency from pin to the FSM is 2 cycles.
- State IDLE: on a falling edge of the line (history=1, line=0), clear the bit counter and go to START.
- State START: count HALF_CLKS cycles, then sample the line.
  - Sample 0: go to DATA with bit index 0 and the period counter cleared.
  - Sample 1 (glitch): return to IDLE; no error, no pulse.
- State DATA: sample the line every BIT_CLKS cycles, i.e. mid-bit.
  - Samples shift LSB-first into a 10-bit register: the first data bit lands in sh[0], the tenth in sh[9].
  - After the 10th sample, go to STOP.
- State STOP: after BIT_CLKS more cycles, sample the line.
  - Sample 1: go to DECODE.
  - Sample 0: pulse FRAME_ERR, increment ERR_COUNT, go to BREAK.
- State BREAK: wait for line=1, then go to IDLE. This prevents a held-low line from retriggering.
- State DECODE (exactly one cycle):
  - Low nibble = dec(sh[4:0]); high nibble = dec(sh[9:5]).
  - dec table (5B code written MSB..LSB -> nibble):
    - 11110->0, 01001->1, 10100->2, 10101->3
    - 01010->4, 01011->5, 01110->6, 01111->7
    - 10010->8, 10011->9, 10110->A, 10111->B
    - 11010->C, 11011->D, 11100->E, 11101->F
  - Any other code is invalid.
  - Both codes valid: DATA and LED take the decoded byte on the next edge, and DATA_VALID pulses in that same cycle.
  - Either code invalid: DATA is held, SYM_ERR pulses, ERR_COUNT increments (once per frame even if both codes are bad).
  - Then return to IDLE.
- Latency: DATA_VALID rises 2 cycles after the stop-bit sample cycle.
- Back-to-back frames: IDLE is re-entered before the stop bit ends, so a start edge immediately after the stop bit is caught. A minimum of one stop bit is required.
- ERR_COUNT saturates at 255 and never wraps.
- Simultaneous events cannot occur within one frame; error pulses are mutually exclusive.
- A falling edge while in any state other than IDLE is ignored.

Test Plan:
- Reset then idle line: 10 us of RXD_5B=1 -> all outputs 0, BUSY=0, no pulses.
- Frame for 0xA5 sent at BIT_CLKS=362 (start 0; low code 01011 LSB-first as 1,1,0,1,0; high code 10110 as 0,1,1,0,1; stop 1) -> one DATA_VALID pulse, DATA=LED=0xA5, ERR_COUNT=0.
- Frame with low code 00000 and high code valid -> SYM_ERR pulse, DATA keeps its previous value, ERR_COUNT=1, no DATA_VALID.
- Valid codes but stop bit 0, line held low 3 bit times then released -> one FRAME_ERR pulse, BUSY stays high until the line returns to 1, no retrigger, ERR_COUNT increments by 1.
- 100-cycle low glitch on an idle line -> no pulses, BUSY returns to 0 after HALF_CLKS plus sync latency; a following 0x00 frame (codes 11110/11110) decodes to DATA=0x00.
- Two frames back-to-back (0x3C then 0xFF), and a separate run with RESET_N pulsed low mid-DATA -> two DATA_VALID pulses with correct bytes; the reset run produces no output for the truncated frame, and the next full frame decodes correctly.
